// File: rtl/vx_mem_lane_sequencer_pkg.sv
// Shared types and op-field constants for the memory-lane sequencer and the memory stage.
package vx_mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  localparam logic [2:0] NO_MEM_READ  = 3'b111;
  localparam logic [2:0] NO_MEM_WRITE = 3'b111;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  localparam logic [2:0] ST_SB  = 3'b000;
  localparam logic [2:0] ST_SH  = 3'b001;
  localparam logic [2:0] ST_SW  = 3'b010;

  function automatic logic is_mem_op(input logic [2:0] mem_read, input logic [2:0] mem_write);
    return (mem_write != NO_MEM_WRITE) || (mem_read != NO_MEM_READ);
  endfunction

endpackage

// File: rtl/vx_mem_lane_sequencer_if.sv
// Single-lane cache-driver port: request handshake plus read-response return.
interface vx_mem_lane_sequencer_if #(
  parameter int LANE_W = 2
);
  logic              cache_req_valid;
  logic              cache_req_ready;
  logic [31:0]       cache_req_addr;
  logic [31:0]       cache_req_data;
  logic [2:0]        cache_req_mem_read;
  logic [2:0]        cache_req_mem_write;
  logic [LANE_W-1:0] cache_req_lane;
  logic              cache_rsp_valid;
  logic [31:0]       cache_rsp_data;

  modport master (
    output cache_req_valid, cache_req_addr, cache_req_data,
           cache_req_mem_read, cache_req_mem_write, cache_req_lane,
    input  cache_req_ready, cache_rsp_valid, cache_rsp_data
  );

  modport slave (
    input  cache_req_valid, cache_req_addr, cache_req_data,
           cache_req_mem_read, cache_req_mem_write, cache_req_lane,
    output cache_req_ready, cache_rsp_valid, cache_rsp_data
  );
endinterface

// File: rtl/vx_mem_lane_sequencer_prio_enc.sv
// Lowest-set-bit priority encoder: index, one-hot and any-set of an N-bit vector.
module vx_lane_priority_enc #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         any
);
  // Two's-complement trick isolates the lowest set bit.
  assign onehot = vec & (-vec);
  assign any    = |vec;

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end
endmodule

// File: rtl/vx_mem_lane_sequencer.sv
// Serialises an NT-lane memory request onto one cache port, one lane per handshake.
// Optional VX_MEM_COALESCE_EN: loads to the same word are served by a single request.
module vx_mem_lane_sequencer
  import vx_mem_seq_pkg::*;
#(
  parameter int NT     = 4,
  parameter int LANE_W = $clog2(NT),
  parameter int WARP_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NT-1:0]        in_valid,
  input  logic [2:0]           in_mem_read,
  input  logic [2:0]           in_mem_write,
  input  logic [NT*32-1:0]     in_address,
  input  logic [NT*32-1:0]     in_data,
  input  logic [WARP_W-1:0]    in_warp_num,
  output logic                 out_delay,
  vx_mem_lane_sequencer_if.master cache,
  output logic [NT*32-1:0]     out_mem_result,
  output logic [NT-1:0]        out_valid,
  output logic [WARP_W-1:0]    out_warp_num,
  output logic                 out_done
);

  seq_state_e        state, next_state;
  logic [NT-1:0]     pending, mask_q, wait_mask, clear_mask, grant_oh;
  logic [LANE_W-1:0] grant_idx;
  logic              grant_any;
  logic [2:0]        rd_q, wr_q;
  logic [WARP_W-1:0] warp_q;
  logic [31:0]       addr_q   [NT];
  logic [31:0]       data_q   [NT];
  logic [31:0]       result_q [NT];
  logic              start, is_store, handshake;

  vx_lane_priority_enc #(.N(NT), .W(LANE_W)) u_grant (
    .vec    (pending),
    .idx    (grant_idx),
    .onehot (grant_oh),
    .any    (grant_any)
  );

  assign start     = (state == IDLE) && is_mem_op(in_mem_read, in_mem_write) && (in_valid != '0);
  assign is_store  = (wr_q != NO_MEM_WRITE);
  assign handshake = (state == REQ) && grant_any && cache.cache_req_ready;

`ifdef VX_MEM_COALESCE_EN
  always_comb begin
    clear_mask = grant_oh;
    if (!is_store) begin
      for (int i = 0; i < NT; i++) begin
        if (pending[i] && (addr_q[i][31:2] == addr_q[grant_idx][31:2])) clear_mask[i] = 1'b1;
      end
    end
  end
`else
  assign clear_mask = grant_oh;
`endif

  always_comb begin
    // NOTE: every path starts from a default so no latch is inferred for next_state.
    next_state = state;
    unique case (state)
      IDLE: if (start) next_state = REQ;
      REQ: begin
        if (handshake) begin
          if (!is_store)                        next_state = WAIT;
          else if ((pending & ~clear_mask) == '0) next_state = DONE;
        end
      end
      WAIT: if (cache.cache_rsp_valid) next_state = (pending == '0) ? DONE : REQ;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the result array is reset explicitly; results are architecturally visible and must read 0.
      state     <= IDLE;
      pending   <= '0;
      mask_q    <= '0;
      wait_mask <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      warp_q    <= '0;
      for (int i = 0; i < NT; i++) begin
        addr_q[i]   <= '0;
        data_q[i]   <= '0;
        result_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      state <= next_state;
      unique case (state)
        IDLE: begin
          if (start) begin
            pending <= in_valid;
            mask_q  <= in_valid;
            rd_q    <= in_mem_read;
            wr_q    <= in_mem_write;
            warp_q  <= in_warp_num;
            for (int i = 0; i < NT; i++) begin
              addr_q[i]   <= in_address[32*i +: 32];
              data_q[i]   <= in_data[32*i +: 32];
              result_q[i] <= '0;
            end
          end
        end
        REQ: begin
          if (handshake) begin
            pending   <= pending & ~clear_mask;
            wait_mask <= clear_mask;
          end
        end
        WAIT: begin
          if (cache.cache_rsp_valid) begin
            for (int i = 0; i < NT; i++) begin
              if (wait_mask[i]) result_q[i] <= cache.cache_rsp_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cache.cache_req_valid     = (state == REQ) && grant_any;
  assign cache.cache_req_addr      = (state == REQ) ? addr_q[grant_idx] : '0;
  assign cache.cache_req_data      = (state == REQ) ? data_q[grant_idx] : '0;
  assign cache.cache_req_lane      = (state == REQ) ? grant_idx : '0;
  assign cache.cache_req_mem_read  = rd_q;
  assign cache.cache_req_mem_write = wr_q;

  assign out_delay    = start || (state == REQ) || (state == WAIT);
  assign out_done     = (state == DONE);
  assign out_valid    = out_done ? mask_q : '0;
  assign out_warp_num = warp_q;

  for (genvar g = 0; g < NT; g++) begin : g_result
    assign out_mem_result[32*g +: 32] = result_q[g];
  end

endmodule

// File: tb/tb_vx_mem_lane_sequencer.sv
// Scoreboard bench for vx_mem_lane_sequencer: expected requests/completions queued at issue, checked by a monitor.
module tb_vx_mem_lane_sequencer;
  import vx_mem_seq_pkg::*;

  localparam int NT     = 4;
  localparam int LANE_W = 2;
  localparam int WARP_W = 2;

  logic              clk;
  logic              reset;
  logic [NT-1:0]     in_valid;
  logic [2:0]        in_mem_read, in_mem_write;
  logic [NT*32-1:0]  in_address, in_data;
  logic [WARP_W-1:0] in_warp_num;
  logic              out_delay;
  logic [NT*32-1:0]  out_mem_result;
  logic [NT-1:0]     out_valid;
  logic [WARP_W-1:0] out_warp_num;
  logic              out_done;

  vx_mem_lane_sequencer_if #(.LANE_W(LANE_W)) cache_if ();

  vx_mem_lane_sequencer #(.NT(NT), .LANE_W(LANE_W), .WARP_W(WARP_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_mem_read    (in_mem_read),
    .in_mem_write   (in_mem_write),
    .in_address     (in_address),
    .in_data        (in_data),
    .in_warp_num    (in_warp_num),
    .out_delay      (out_delay),
    .cache          (cache_if),
    .out_mem_result (out_mem_result),
    .out_valid      (out_valid),
    .out_warp_num   (out_warp_num),
    .out_done       (out_done)
  );

  typedef struct {
    logic [LANE_W-1:0] lane;
    logic [31:0]       addr;
    logic [31:0]       data;
    logic [2:0]        rd;
    logic [2:0]        wr;
  } req_t;

  typedef struct {
    logic [NT*32-1:0]  result;
    logic [NT-1:0]     valid;
    logic [WARP_W-1:0] warp;
    int                latency;
  } done_t;

  req_t  exp_req_q  [$];
  done_t exp_done_q [$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_done   = 0;
  int    cyc      = 0;
  int    accept_cyc = 0;
  logic  rsp_auto;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [NT*32-1:0] act, input logic [NT*32-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic [LANE_W-1:0] lane, input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] rd, input logic [2:0] wr);
    req_t r;
    r.lane = lane; r.addr = addr; r.data = data; r.rd = rd; r.wr = wr;
    exp_req_q.push_back(r);
  endtask

  task automatic push_done(input logic [NT*32-1:0] result, input logic [NT-1:0] valid,
                           input logic [WARP_W-1:0] warp, input int latency);
    done_t d;
    d.result = result; d.valid = valid; d.warp = warp; d.latency = latency;
    exp_done_q.push_back(d);
  endtask

  task automatic idle_inputs();
    in_valid     = '0;
    in_mem_read  = NO_MEM_READ;
    in_mem_write = NO_MEM_WRITE;
    in_address   = '0;
    in_data      = '0;
    in_warp_num  = '0;
  endtask

  task automatic drive(input logic [NT-1:0] mask, input logic [2:0] rd, input logic [2:0] wr,
                       input logic [NT*32-1:0] addr, input logic [NT*32-1:0] data,
                       input logic [WARP_W-1:0] warp);
    in_valid     = mask;
    in_mem_read  = rd;
    in_mem_write = wr;
    in_address   = addr;
    in_data      = data;
    in_warp_num  = warp;
    accept_cyc   = cyc;
  endtask

  task automatic wait_done(input string name);
    int base;
    base = n_done;
    for (int i = 0; i < 60 && n_done == base; i++) begin
      @(negedge clk);
      #1;
    end
    check({name, "_done_seen"}, n_done - base, 1);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // Monitor: compares every request handshake and completion against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (cache_if.cache_req_valid && cache_if.cache_req_ready) begin
        if (exp_req_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: lane=%0d addr=%0h, required no request", cache_if.cache_req_lane, cache_if.cache_req_addr);
        end else begin
          req_t r;
          r = exp_req_q.pop_front();
          check("req_lane", cache_if.cache_req_lane, r.lane);
          check("req_addr", cache_if.cache_req_addr, r.addr);
          check("req_data", cache_if.cache_req_data, r.data);
          check("req_mem_read", cache_if.cache_req_mem_read, r.rd);
          check("req_mem_write", cache_if.cache_req_mem_write, r.wr);
        end
      end
      if (out_done) begin
        if (exp_done_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: out_valid=%0b, required no completion", out_valid);
        end else begin
          done_t d;
          d = exp_done_q.pop_front();
          check("done_results", out_mem_result, d.result);
          check("done_valid", out_valid, d.valid);
          check("done_warp", out_warp_num, d.warp);
          check("done_latency", cyc - accept_cyc, d.latency);
        end
        n_done++;
      end
    end
  end

  // Zero-wait cache: answers each load handshake in the following cycle.
  initial forever begin
    logic [31:0] a;
    @(negedge clk);
    if (rsp_auto && reset && cache_if.cache_req_valid && cache_if.cache_req_ready) begin
      a = cache_if.cache_req_addr;
      @(posedge clk);
      #1;
      cache_if.cache_rsp_valid = 1'b1;
      cache_if.cache_rsp_data  = {16'hDA7A, a[15:0]};
      @(posedge clk);
      #1;
      cache_if.cache_rsp_valid = 1'b0;
    end
  end

  initial begin
    reset = 1'b0;
    rsp_auto = 1'b1;
    idle_inputs();
    cache_if.cache_req_ready = 1'b1;
    cache_if.cache_rsp_valid = 1'b0;
    cache_if.cache_rsp_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_out_delay", out_delay, 0);
    check("rst_req_valid", cache_if.cache_req_valid, 0);
    check("rst_out_done", out_done, 0);
    check("rst_results", out_mem_result, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_warp", out_warp_num, 0);
    check("rst_req_mem_read", cache_if.cache_req_mem_read, 0);
    check("rst_req_addr", cache_if.cache_req_addr, 0);

    // LW, mask 1011: lanes 0,1,3, done seven cycles after acceptance.
    @(posedge clk);
    #1;
    drive(4'b1011, LD_LW, NO_MEM_WRITE,
          {32'h0000_010C, 32'h0000_0000, 32'h0000_0104, 32'h0000_0100}, '0, 2'd2);
    push_req(2'd0, 32'h0000_0100, 32'h0, LD_LW, NO_MEM_WRITE);
    push_req(2'd1, 32'h0000_0104, 32'h0, LD_LW, NO_MEM_WRITE);
    push_req(2'd3, 32'h0000_010C, 32'h0, LD_LW, NO_MEM_WRITE);
    push_done({32'hDA7A_010C, 32'h0, 32'hDA7A_0104, 32'hDA7A_0100}, 4'b1011, 2'd2, 7);
    #1;
    check("lw_out_delay_accept", out_delay, 1);
    wait_done("lw");

    // SW, mask 0110 with ready held low for two cycles.
    rsp_auto = 1'b0;
    @(posedge clk);
    #1;
    cache_if.cache_req_ready = 1'b0;
    drive(4'b0110, NO_MEM_READ, ST_SW,
          {32'hDEAD_0000, 32'h2000_0008, 32'h2000_0004, 32'hDEAD_0000},
          {32'h9999_9999, 32'h2222_2222, 32'h1111_1111, 32'h9999_9999}, 2'd1);
    push_req(2'd1, 32'h2000_0004, 32'h1111_1111, NO_MEM_READ, ST_SW);
    push_req(2'd2, 32'h2000_0008, 32'h2222_2222, NO_MEM_READ, ST_SW);
    push_done('0, 4'b0110, 2'd1, 5);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("sw_stall_valid", cache_if.cache_req_valid, 1);
      check("sw_stall_addr", cache_if.cache_req_addr, 32'h2000_0004);
      check("sw_stall_data", cache_if.cache_req_data, 32'h1111_1111);
      check("sw_stall_lane", cache_if.cache_req_lane, 2'd1);
    end
    @(posedge clk);
    #1;
    cache_if.cache_req_ready = 1'b1;
    wait_done("sw");
    rsp_auto = 1'b1;

    // Non-memory op with full mask: never busy, never requests.
    @(posedge clk);
    #1;
    drive(4'b1111, NO_MEM_READ, NO_MEM_WRITE, {4{32'h0000_0400}}, '0, 2'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("nop_out_delay", out_delay, 0);
      check("nop_req_valid", cache_if.cache_req_valid, 0);
    end
    idle_inputs();

    // LW with empty mask: never busy, never requests, never completes.
    @(posedge clk);
    #1;
    drive(4'b0000, LD_LW, NO_MEM_WRITE, {4{32'h0000_0500}}, '0, 2'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mask0_out_delay", out_delay, 0);
      check("mask0_req_valid", cache_if.cache_req_valid, 0);
      check("mask0_out_done", out_done, 0);
    end
    idle_inputs();

    // Reset while waiting for a load response; the late response must be dropped.
    rsp_auto = 1'b0;
    @(posedge clk);
    #1;
    drive(4'b0001, LD_LW, NO_MEM_WRITE, {96'h0, 32'h0000_0300}, '0, 2'd3);
    push_req(2'd0, 32'h0000_0300, 32'h0, LD_LW, NO_MEM_WRITE);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("midrst_out_delay", out_delay, 0);
    check("midrst_req_valid", cache_if.cache_req_valid, 0);
    check("midrst_warp", out_warp_num, 0);
    check("midrst_req_mem_read", cache_if.cache_req_mem_read, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    cache_if.cache_rsp_valid = 1'b1;
    cache_if.cache_rsp_data  = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    cache_if.cache_rsp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("postrst_results", out_mem_result, 0);
      check("postrst_out_delay", out_delay, 0);
      check("postrst_out_valid", out_valid, 0);
    end
    rsp_auto = 1'b1;

    // LW, all lanes to 0x200: coalesced into one request when the option is built in.
    @(posedge clk);
    #1;
    drive(4'b1111, LD_LW, NO_MEM_WRITE, {4{32'h0000_0200}}, '0, 2'd1);
`ifdef VX_MEM_COALESCE_EN
    push_req(2'd0, 32'h0000_0200, 32'h0, LD_LW, NO_MEM_WRITE);
    push_done({4{32'hDA7A_0200}}, 4'b1111, 2'd1, 3);
`else
    for (int l = 0; l < NT; l++) push_req(LANE_W'(l), 32'h0000_0200, 32'h0, LD_LW, NO_MEM_WRITE);
    push_done({4{32'hDA7A_0200}}, 4'b1111, 2'd1, 9);
`endif
    wait_done("same_addr");

    repeat (3) @(posedge clk);
    #1;
    check("req_queue_drained", exp_req_q.size(), 0);
    check("done_queue_drained", exp_done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_mem_lane_sequencer.md
Name: vx_mem_lane_sequencer

Overview:
- Sequences the memory stage's NT-lane load/store request onto a single-lane cache-driver port.
- Issues one active lane per handshake and collects read responses into per-lane result registers.
- Stalls upstream via out_delay until every active lane has completed.
- Sits between the memory stage and the cache driver; replaces the current all-lanes-in-parallel cache connection.

Parameters:
- NT, 4, number of thread lanes (power of 2, ≥2)
- LANE_W, $clog2(NT), lane index width
- WARP_W, 2, warp number width

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  NT  active-lane mask
- in_mem_read  input  3  load type; 3'b111 = none
- in_mem_write  input  3  store type; 3'b111 = none
- in_address  input  NT*32  per-lane address, lane i at [32i+31:32i]
- in_data  input  NT*32  per-lane store data
- in_warp_num  input  WARP_W  warp of request
- out_delay  output  1  upstream must hold its inputs while high
- cache_req_valid  output  1  request valid
- cache_req_ready  input  1  cache accepts request
- cache_req_addr  output  32  granted lane's address
- cache_req_data  output  32  granted lane's store data
- cache_req_mem_read  output  3  latched load type
- cache_req_mem_write  output  3  latched store type
- cache_req_lane  output  LANE_W  granted lane index
- cache_rsp_valid  input  1  read response valid
- cache_rsp_data  input  32  read response data
- out_mem_result  output  NT*32  per-lane load results
- out_valid  output  NT  latched mask, qualified by out_done
- out_warp_num  output  WARP_W  latched warp
- out_done  output  1  one-cycle completion pulse

Behaviour:
- Memory op: in_mem_write != 3'b111 (store; takes priority if both fields are set) or in_mem_read != 3'b111 (load).
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE → REQ when start = memory op && in_valid != 0:
  - latch mask into pending, plus addresses, data, op fields and warp
  - clear all result registers to 0
  - out_delay is combinationally 1 in this cycle
- IDLE otherwise (non-memory op or zero mask): out_delay = 0, no request.
- REQ:
  - granted lane = lowest set bit of pending
  - cache_req_valid = 1; addr, data and lane are stable until handshake
  - on handshake, clear the pending bit
  - store: go to DONE if pending is now empty, else stay in REQ
  - load: go to WAIT
- WAIT:
  - cache_req_valid = 0
  - on cache_rsp_valid, write cache_rsp_data into result[granted lane]
  - then go to DONE if pending is empty, else REQ
- DONE:
  - out_done = 1 and out_delay = 0; upstream advances this cycle
  - no new request is accepted in DONE; next state is IDLE
- out_delay = start || state ∈ {REQ, WAIT}.
- cache_rsp_valid outside WAIT is ignored.
- Results, out_valid and out_warp_num hold until the next acceptance.
- Latency with a zero-wait cache:
  - loads: 1 + 2·k cycles from acceptance to out_done, for k active lanes
  - stores: 1 + k cycles
- Reset (async assert, any state including mid-operation):
  - state IDLE, pending 0, all registers and outputs 0
  - in-flight transaction dropped; a response arriving after reset is ignored

Optional Feature:
- Macro VX_MEM_COALESCE_EN.
- Defined: on a load handshake, every pending lane whose address[31:2] equals the granted lane's also clears its pending bit; the response is written to all of those lanes.
- Stores are never coalesced.
- Undefined: one request per active lane, always.

Decomposition:
- Package vx_mem_seq_pkg holds:
  - state enum
  - NO_MEM_READ / NO_MEM_WRITE = 3'b111
  - load/store type constants shared with the memory stage
- One sub-module, vx_lane_priority_enc (NT-bit vector in; lowest-set index, one-hot and any-set out), instantiated once for the grant.

Test Plan:
- LW, mask 4'b1011, addrs 0x100/0x104/x/0x10C, ready=1, responses A/B/D one cycle after each grant → requests to lanes 0,1,3 in order; out_done at cycle 7; results {D,0,B,A}.
- SW, mask 4'b0110, ready held low 2 cycles → req addr/data/lane stable while stalled; 2 handshakes, no WAIT, out_done follows the last handshake.
- mem_read = mem_write = 3'b111 with mask 4'b1111 → out_delay 0, cache_req_valid never asserted.
- LW with mask 0 → no request, out_delay 0, out_done 0.
- Reset asserted in WAIT, rsp_valid pulses one cycle after release → state IDLE, results 0, response ignored.
- LW, all lanes addr 0x200: macro defined → one request, all four results equal the response; macro undefined → four requests.
